// File: rtl/spi_txn_fsm.sv
// -----------------------------------------------------------------------------
// spi_txn_fsm
//
// Transaction controller for the SPI slave. It sequences one transaction:
// ADDR_BITS address bits, one R/W bit, then DATA_BITS data bits, either shifted
// in from MOSI (write) or shifted out on MISO (read).
//
// Ports:
//   clk       system clock
//   reset_n   synchronous active-low reset
//   cs_n      conditioned chip select, active low
//   sclk_pos  one-cycle SCLK rising-edge pulse
//   sclk_neg  one-cycle SCLK falling-edge pulse
//   rw_bit    shift register parallelOut[0] (last bit shifted in)
//   sr_shift  shift-register serial-shift enable (same cycle as the edge pulse)
//   sr_load   shift-register parallel-load enable
//   addr_we   address latch write enable
//   dm_we     data memory write enable
//   miso_en   MISO buffer enable
//   busy      high in any state other than idle
// -----------------------------------------------------------------------------
module spi_txn_fsm #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter int MEM_LAT   = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cs_n,
    input  logic sclk_pos,
    input  logic sclk_neg,
    input  logic rw_bit,
    output logic sr_shift,
    output logic sr_load,
    output logic addr_we,
    output logic dm_we,
    output logic miso_en,
    output logic busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [3:0] {
        s_idle,
        s_addr,
        s_latch,
        s_rwait,
        s_rload,
        s_rshift,
        s_wshift,
        s_wmem,
        s_done
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               rw_reg;
    logic               rw_next;

    logic               cnt_inc;
    logic               shift_req;
    logic               load_req;
    logic               addr_req;
    logic               dm_req;
    logic               miso_req;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= s_idle;
            cnt_reg   <= '0;
            rw_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rw_reg    <= rw_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        rw_next    = rw_reg;
        cnt_inc    = 1'b0;
        shift_req  = 1'b0;
        load_req   = 1'b0;
        addr_req   = 1'b0;
        dm_req     = 1'b0;
        miso_req   = 1'b0;

        case (state_reg)
            s_idle: begin
                if (!cs_n) begin
                    state_next = s_addr;
                end
            end

            // Address bits followed by the R/W bit, all sampled on SCLK rise.
            s_addr: begin
                if (sclk_pos) begin
                    shift_req = 1'b1;
                    cnt_inc   = 1'b1;
                    if (cnt_reg == CNT_W'(ADDR_BITS)) begin
                        state_next = s_latch;
                    end
                end
            end

            // The R/W bit reached parallelOut[0] on the previous edge.
            s_latch: begin
                addr_req   = 1'b1;
                rw_next    = rw_bit;
                state_next = rw_bit ? s_rwait : s_wshift;
            end

            // Counts clk cycles (not SCLK) while the memory read settles.
            s_rwait: begin
                cnt_inc = 1'b1;
                if (cnt_reg == CNT_W'(MEM_LAT - 1)) begin
                    state_next = s_rload;
                end
            end

            s_rload: begin
                load_req   = 1'b1;
                miso_req   = rw_reg;
                state_next = s_rshift;
            end

            // The loaded MSB is already on MISO, so the first falling edge
            // (end of the R/W bit period) and the last one do not shift.
            s_rshift: begin
                miso_req = rw_reg;
                if (sclk_neg) begin
                    cnt_inc = 1'b1;
                    if (cnt_reg == CNT_W'(DATA_BITS)) begin
                        state_next = s_done;
                    end else if (cnt_reg != '0) begin
                        shift_req = 1'b1;
                    end
                end
            end

            s_wshift: begin
                if (sclk_pos) begin
                    shift_req = 1'b1;
                    cnt_inc   = 1'b1;
                    if (cnt_reg == CNT_W'(DATA_BITS - 1)) begin
                        state_next = s_wmem;
                    end
                end
            end

            s_wmem: begin
                dm_req     = 1'b1;
                state_next = s_done;
            end

            // Waits for chip select to drop; further SCLK edges are ignored.
            s_done: begin
            end

            default: begin
                state_next = s_idle;
            end
        endcase

        // Deselect aborts from any active state and beats a coincident edge.
        if ((state_reg != s_idle) && cs_n) begin
            state_next = s_idle;
            shift_req  = 1'b0;
        end

        cnt_next = (state_next != state_reg) ? '0 : (cnt_reg + CNT_W'(cnt_inc));
    end

    // Outputs are held low while reset is asserted.
    assign sr_shift = reset_n & shift_req;
    assign sr_load  = reset_n & load_req;
    assign addr_we  = reset_n & addr_req;
    assign dm_we    = reset_n & dm_req;
    assign miso_en  = reset_n & miso_req;
    assign busy     = reset_n & (state_reg != s_idle);

endmodule
